axi4_stream_arb: RTL

- Packet-aware N:1 AXI4-Stream multiplexer/arbiter; successor to the combinational stream mux.
- Holds a grant for a whole packet (released on the TLAST beat), chooses the next source by manual select, round-robin or fixed priority, and registers the output through a full-throughput skid slice.
- Sits in front of shared stream consumers (DMA writer, scope/generator paths) fed by several acquisition channels.

---
 rtl/axi4_stream_pkg.sv | 38 +++
 rtl/axi4_stream_if.sv | 24 ++
 rtl/axi4_stream_skid.sv | 78 +++++++
 rtl/axi4_stream_arb.sv | 134 +++++++++++++
 4 files changed

// File: rtl/axi4_stream_pkg.sv
// axi4_stream_pkg: arbitration mode encoding and round-robin helper
// shared by the AXI4-Stream arbiter files.
package axi4_stream_pkg;

    typedef enum logic [1:0] {
        ARB_MANUAL,
        ARB_RR,
        ARB_PRIO
    } arb_mode_t;

    // Widest request vector rr_next can scan.
    localparam int RR_MAX = 32;

    // First set bit of valid strictly after index last, wrapping at n-1.
    // Returns last when nothing is set; callers gate with |valid.
    function automatic int rr_next(
        input logic [RR_MAX-1:0] valid,
        input int                last,
        input int                n
    );
        int         idx;
        logic [4:0] bit_i;
        logic       found;
        rr_next = last;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            if (!found && k <= n) begin
                idx   = (last + k) % n;
                bit_i = 5'(idx);
                if (valid[bit_i]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: one AXI4-Stream link.
// Modport s drives the beat (source side), d receives it (sink side).
interface axi4_stream_if #(
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
) ();

    DT [DN-1:0] TDATA;
    logic       TKEEP;
    logic       TLAST;
    logic       TVALID;
    logic       TREADY;

    modport s (
        output TDATA, TKEEP, TLAST, TVALID,
        input  TREADY
    );

    modport d (
        input  TDATA, TKEEP, TLAST, TVALID,
        output TREADY
    );

endinterface

// File: rtl/axi4_stream_skid.sv
// axi4_stream_skid: 2-entry registered stream slice, full throughput.
// Ports: clk, rst (sync, active-high), up (sink side), dn (source side).
// dn.T* and up.TREADY all come straight from flops.
module axi4_stream_skid #(
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
) (
    input  logic     clk,
    input  logic     rst,
    axi4_stream_if.d up,
    axi4_stream_if.s dn
);

    typedef struct packed {
        DT [DN-1:0] data;
        logic       keep;
        logic       last;
    } beat_t;

    beat_t in_beat;
    beat_t out_q, out_d;
    beat_t skb_q, skb_d;
    logic  out_vld_q, out_vld_d;
    logic  skb_vld_q, skb_vld_d;
    logic  rdy_q, rdy_d;
    logic  in_xfer;

    assign in_beat = {up.TDATA, up.TKEEP, up.TLAST};
    assign in_xfer = up.TVALID && rdy_q;

    assign up.TREADY = rdy_q;
    assign dn.TVALID = out_vld_q;
    assign dn.TDATA  = out_q.data;
    assign dn.TKEEP  = out_q.keep;
    assign dn.TLAST  = out_q.last;

    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        skb_d     = skb_q;
        skb_vld_d = skb_vld_q;
        if (!out_vld_q || dn.TREADY) begin
            // Output slot frees up: the skid entry is older, drain it first.
            if (skb_vld_q) begin
                out_d     = skb_q;
                out_vld_d = 1'b1;
                skb_vld_d = 1'b0;
            end else begin
                out_vld_d = in_xfer;
                if (in_xfer) begin
                    out_d = in_beat;
                end
            end
        end else if (in_xfer) begin
            // Stalled: park the beat that was already in flight.
            skb_d     = in_beat;
            skb_vld_d = 1'b1;
        end
        rdy_d = !skb_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            skb_q     <= '0;
            skb_vld_q <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            skb_q     <= skb_d;
            skb_vld_q <= skb_vld_d;
            rdy_q     <= rdy_d;
        end
    end

endmodule

// File: rtl/axi4_stream_arb.sv
// axi4_stream_arb: packet-aware N:1 AXI4-Stream arbiter with output slice.
// Ports: clk, rst (sync, active-high), mode (0 man/1 rr/2 prio/3 man),
// sel (manual source), sti[SN] inputs, sto output, gnt, busy.
module axi4_stream_arb
    import axi4_stream_pkg::*;
#(
    parameter int  SN = 2,
    parameter int  SW = $clog2(SN),
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] sel,
    axi4_stream_if.d      sti [SN-1:0],
    axi4_stream_if.s      sto,
    output logic [SW-1:0] gnt,
    output logic          busy
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    typedef struct packed {
        DT [DN-1:0] data;
        logic       keep;
        logic       last;
    } beat_t;

    state_t        state_q;
    logic [SW-1:0] gnt_q;
    logic [SW-1:0] ptr_q;
    logic          rr_q;

    logic [SN-1:0] vld;
    logic [SN-1:0] rdy;
    beat_t         beat [SN];
    beat_t         sel_beat;

    logic          cand_ok;
    logic [SW-1:0] cand;
    logic [SW-1:0] prio_idx;
    logic [SW-1:0] rr_idx;
    logic          man_ok;
    logic          xfer;

    axi4_stream_if #(.DN(DN), .DT(DT)) mid ();

    // Interface arrays only take constant indices, so flatten them here.
    for (genvar i = 0; i < SN; i++) begin : g_src
        assign vld[i]  = sti[i].TVALID;
        assign beat[i] = {sti[i].TDATA, sti[i].TKEEP, sti[i].TLAST};
        assign sti[i].TREADY = rdy[i];
    end

    always_comb begin
        prio_idx = '0;
        for (int i = SN - 1; i >= 0; i--) begin
            if (vld[i]) begin
                prio_idx = SW'(i);
            end
        end
        rr_idx = SW'(rr_next(RR_MAX'(vld), int'(ptr_q), SN));
        man_ok = (32'(sel) < 32'(SN)) && vld[sel];
        case (mode)
            ARB_RR: begin
                cand_ok = |vld;
                cand    = rr_idx;
            end
            ARB_PRIO: begin
                cand_ok = |vld;
                cand    = prio_idx;
            end
            default: begin
                cand_ok = man_ok;
                cand    = sel;
            end
        endcase
    end

    assign sel_beat   = beat[gnt_q];
    assign mid.TVALID = (state_q == S_BUSY) && vld[gnt_q];
    assign mid.TDATA  = sel_beat.data;
    assign mid.TKEEP  = sel_beat.keep;
    assign mid.TLAST  = sel_beat.last;
    assign xfer       = mid.TVALID && mid.TREADY;

    always_comb begin
        rdy = '0;
        if (state_q == S_BUSY) begin
            rdy[gnt_q] = mid.TREADY;
        end
    end

    // rr_q remembers the mode at grant time so a mode change mid-packet
    // does not decide whether the pointer moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= SW'(SN - 1);
            rr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cand_ok) begin
                        state_q <= S_BUSY;
                        gnt_q   <= cand;
                        rr_q    <= (mode == ARB_RR);
                    end
                end
                S_BUSY: begin
                    if (xfer && sel_beat.last) begin
                        state_q <= S_IDLE;
                        if (rr_q) begin
                            ptr_q <= gnt_q;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == S_BUSY);

    axi4_stream_skid #(.DN(DN), .DT(DT)) u_skid (
        .clk (clk),
        .rst (rst),
        .up  (mid),
        .dn  (sto)
    );

endmodule
